uart_sr_tx_sequencer: RTL and testbench

- Transmit controller for the UART TX port.
- On a start pulse it snapshots the packed character buffer produced by uart_sr_input and drives the UART tx_data/tx_valid/tx_ready handshake one character at a time, oldest first.
- Optionally skips null bytes and appends a terminator character.
- Sits between uart_sr_input (sr_data) and the uart TX interface, giving the design a "read back the last N characters" path.

---
 rtl/uart_sr_tx_sequencer_if.sv | 11 +
 rtl/uart_sr_tx_sequencer.sv | 153 +++++++++++++++
 tb/tb_uart_sr_tx_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_sr_tx_sequencer_if.sv
// Character handshake between the TX sequencer (master) and the UART transmitter (slave).
interface uart_sr_tx_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sr_tx_sequencer.sv
// Snapshots the packed character buffer on start and feeds it to the UART oldest-first,
// optionally skipping null characters and appending a terminator.
module uart_sr_tx_sequencer #(
    parameter int unsigned          DATA_WIDTH      = 8,
    parameter int unsigned          CHARACTER_COUNT = 10,
    parameter bit                   SKIP_NULL       = 1'b1,
    parameter bit                   APPEND_EOL      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] EOL_CHAR       = DATA_WIDTH'(8'h0A)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ena,
    input  logic                                  start,
    input  logic [DATA_WIDTH*CHARACTER_COUNT-1:0] buf_data,
    output logic                                  busy,
    output logic                                  done,
    uart_sr_tx_sequencer_if.master                tx_if
);

    localparam int unsigned BUF_W = DATA_WIDTH * CHARACTER_COUNT;
    localparam int unsigned IDX_W = (CHARACTER_COUNT > 1) ? $clog2(CHARACTER_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARACTER_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SEND,
        ST_DRAIN,
        ST_ADVANCE,
        ST_SEND_EOL,
        ST_DRAIN_EOL,
        ST_FINISH
    } state_t;

    state_t                r_state, w_state;
    logic [IDX_W-1:0]      r_index, w_index;
    logic [BUF_W-1:0]      r_snapshot, w_snapshot;
    logic                  r_eol_pending, w_eol_pending;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data;
    logic                  r_tx_valid, w_tx_valid;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic [DATA_WIDTH-1:0] w_char;

    // State and output registers; ena low freezes everything, including a pending done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_snapshot    <= '0;
            r_eol_pending <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (ena) begin
            r_state       <= w_state;
            r_index       <= w_index;
            r_snapshot    <= w_snapshot;
            r_eol_pending <= w_eol_pending;
            r_tx_data     <= w_tx_data;
            r_tx_valid    <= w_tx_valid;
            r_busy        <= w_busy;
            r_done        <= w_done;
        end
    end

    assign w_char = r_snapshot[32'(r_index) * DATA_WIDTH +: DATA_WIDTH];

    // Next-state and next-output logic.
    always_comb begin
        w_state       = r_state;
        w_index       = r_index;
        w_snapshot    = r_snapshot;
        w_eol_pending = r_eol_pending;
        w_tx_data     = r_tx_data;
        w_tx_valid    = r_tx_valid;
        w_busy        = 1'b1;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_snapshot    = buf_data;
                    w_index       = LAST_IDX;
                    w_eol_pending = APPEND_EOL;
                    w_state       = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (SKIP_NULL && (w_char == '0)) begin
                    w_state = ST_ADVANCE;
                end else begin
                    w_tx_data  = w_char;
                    w_tx_valid = 1'b1;
                    w_state    = ST_SEND;
                end
            end
            // Request stays up until the UART has visibly gone busy.
            ST_SEND: begin
                if (!tx_if.tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_state    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tx_if.tx_ready) begin
                    w_state = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                if (r_index != '0) begin
                    w_index = r_index - IDX_W'(1);
                    w_state = ST_SELECT;
                end else if (r_eol_pending) begin
                    w_eol_pending = 1'b0;
                    w_tx_data     = EOL_CHAR;
                    w_tx_valid    = 1'b1;
                    w_state       = ST_SEND_EOL;
                end else begin
                    w_state = ST_FINISH;
                end
            end
            ST_SEND_EOL: begin
                if (!tx_if.tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_state    = ST_DRAIN_EOL;
                end
            end
            ST_DRAIN_EOL: begin
                if (tx_if.tx_ready) begin
                    w_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = ST_IDLE;
            end
            default: begin
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
        endcase
    end

    assign tx_if.tx_data  = r_tx_data;
    assign tx_if.tx_valid = r_tx_valid;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_uart_sr_tx_sequencer.sv
// Scoreboard bench: a UART loopback model captures each request and compares it to queued expectations.
module tb_uart_sr_tx_sequencer;

    localparam int unsigned DW    = 8;
    localparam int unsigned CC    = 4;
    localparam int unsigned FRAME = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena;
    logic        start_a, start_b;
    logic [31:0] buf_a, buf_b;
    logic        busy_a, done_a, busy_b, done_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int rx_cnt = 0;
    logic [7:0] exp_q[$];
    int         rx_time[$];

    uart_sr_tx_sequencer_if #(.DATA_WIDTH(DW)) if_a ();
    uart_sr_tx_sequencer_if #(.DATA_WIDTH(DW)) if_b ();

    uart_sr_tx_sequencer #(
        .DATA_WIDTH(DW), .CHARACTER_COUNT(CC), .SKIP_NULL(1'b1),
        .APPEND_EOL(1'b1), .EOL_CHAR(8'h0A)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .ena(ena), .start(start_a),
        .buf_data(buf_a), .busy(busy_a), .done(done_a), .tx_if(if_a)
    );

    uart_sr_tx_sequencer #(
        .DATA_WIDTH(DW), .CHARACTER_COUNT(CC), .SKIP_NULL(1'b1),
        .APPEND_EOL(1'b0), .EOL_CHAR(8'h0A)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .ena(ena), .start(start_b),
        .buf_data(buf_b), .busy(busy_b), .done(done_b), .tx_if(if_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // UART loopback: accepts a request, goes busy for FRAME cycles, then idles again.
    initial begin
        if_a.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (if_a.tx_valid && if_a.tx_ready) begin
                rx_cnt++;
                rx_time.push_back(cyc);
                if (exp_q.size() == 0) check("rx_unexpected", 32'(if_a.tx_data), 32'h100);
                else                   check("rx_byte", 32'(if_a.tx_data), 32'(exp_q.pop_front()));
                if_a.tx_ready = 1'b0;
                repeat (FRAME) @(negedge clk);
                if_a.tx_ready = 1'b1;
            end
        end
    end

    initial if_b.tx_ready = 1'b1;

    // Pulse start on dut_a and queue the characters it should emit; k is the sampling edge.
    task automatic send_a(input logic [31:0] b, output int k);
        logic [7:0] c;
        @(negedge clk);
        buf_a   = b;
        start_a = 1'b1;
        for (int i = int'(CC) - 1; i >= 0; i--) begin
            c = b[i*8 +: 8];
            if (c != 8'h00) exp_q.push_back(c);
        end
        exp_q.push_back(8'h0A);
        @(negedge clk);
        start_a = 1'b0;
        k = cyc;
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        int gaps  = 0;
        int extra = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
            else if (!busy_a) gaps++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_gaps"}, 32'(gaps), 32'd0);
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (done_a) extra++;
        end
        check({tag, "_extra_done"}, 32'(extra), 32'd0);
        check({tag, "_busy_after"}, 32'(busy_a), 32'd0);
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int k1, k2, k;
        int l1, g, ge;
        int base, vcnt, bcnt, first_busy, done_at, changes, dhigh;
        bit found;
        logic [DW+2:0] snap;

        reset_n = 1'b0; ena = 1'b1; start_a = 1'b0; start_b = 1'b0;
        buf_a = '0; buf_b = '0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid_a", 32'(if_a.tx_valid), 32'd0);
        check("rst_tx_data_a", 32'(if_a.tx_data), 32'd0);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_tx_valid_b", 32'(if_b.tx_valid), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full buffer, newest char last, terminator appended.
        rx_time.delete();
        send_a(32'h44_43_42_41, k1);
        wait_done_a("basic", 400);
        check("basic_rx_count", 32'(rx_time.size()), 32'd5);
        check("basic_tx_data_hold", 32'(if_a.tx_data), 32'h0A);
        l1 = rx_time[0] - k1;
        g  = rx_time[1] - rx_time[0];
        ge = rx_time[4] - rx_time[3];
        check("basic_gap_uniform", 32'(rx_time[2] - rx_time[1]), 32'(g));

        // Skipped nulls cost exactly two extra cycles each.
        rx_time.delete();
        send_a(32'h00_42_00_41, k2);
        wait_done_a("skip", 400);
        check("skip_rx_count", 32'(rx_time.size()), 32'd3);
        check("skip_first_lat", 32'(rx_time[0] - k2), 32'(l1 + 2));
        check("skip_gap", 32'(rx_time[1] - rx_time[0]), 32'(g + 2));
        check("skip_eol_gap", 32'(rx_time[2] - rx_time[1]), 32'(ge));

        // All-null buffer without terminator on the second instance.
        @(negedge clk);
        buf_b = '0; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; k = cyc;
        check("null_busy_at_k", 32'(busy_b), 32'd0);
        vcnt = 0; bcnt = 0; first_busy = -1; done_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_b.tx_valid) vcnt++;
            if (busy_b) begin
                bcnt++;
                if (first_busy < 0) first_busy = cyc - k;
            end
            if (done_b && done_at < 0) done_at = cyc - k;
        end
        check("null_no_valid", 32'(vcnt), 32'd0);
        check("null_done_at", 32'(done_at), 32'd9);
        check("null_first_busy", 32'(first_busy), 32'd1);
        check("null_busy_cycles", 32'(bcnt), 32'd8);

        // Buffer change and start pulse mid-sequence are ignored.
        base = rx_cnt;
        send_a(32'h64_63_62_61, k);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rx_cnt >= base + 2) found = 1'b1;
        end
        check("mid_reach_second", 32'(found), 32'd1);
        buf_a = 32'hFF_FF_FF_FF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("mid", 400);

        // Freeze for 500 cycles while draining the first character.
        base = rx_cnt;
        send_a(32'h35_34_33_32, k);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rx_cnt >= base + 1 && !if_a.tx_valid && busy_a) found = 1'b1;
        end
        check("ena_reach_drain", 32'(found), 32'd1);
        ena = 1'b0;
        snap = {if_a.tx_data, if_a.tx_valid, busy_a, done_a};
        changes = 0;
        repeat (500) begin
            @(negedge clk);
            if ({if_a.tx_data, if_a.tx_valid, busy_a, done_a} != snap) changes++;
        end
        check("ena_frozen", 32'(changes), 32'd0);
        check("ena_no_rx", 32'(rx_cnt - base), 32'd1);
        ena = 1'b1;
        wait_done_a("ena", 400);

        // done is held, not re-pulsed, while ena is low.
        send_a(32'h00_00_00_41, k);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (done_a) found = 1'b1;
        end
        check("hold_done_seen", 32'(found), 32'd1);
        ena = 1'b0;
        dhigh = 0;
        repeat (5) begin
            @(negedge clk);
            if (done_a) dhigh++;
        end
        check("hold_done_held", 32'(dhigh), 32'd5);
        ena = 1'b1;
        @(negedge clk);
        check("hold_done_clear", 32'(done_a), 32'd0);
        check("hold_exp_left", 32'(exp_q.size()), 32'd0);

        // Reset while the third character is being requested.
        base = rx_cnt;
        send_a(32'h44_43_42_41, k);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (rx_cnt >= base + 2 && if_a.tx_valid) found = 1'b1;
        end
        check("rst_reach_third", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(if_a.tx_valid), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_done", 32'(done_a), 32'd0);
        check("midrst_tx_data", 32'(if_a.tx_data), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("midrst_rx_count", 32'(rx_cnt - base), 32'd2);
        reset_n = 1'b1;
        repeat (FRAME) @(negedge clk);
        rx_time.delete();
        send_a(32'h44_43_42_41, k);
        wait_done_a("after_rst", 400);
        check("after_rst_rx_count", 32'(rx_time.size()), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
